// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI read arbiter: FSM states, requester ids and
// the reset value of the round-robin history.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    // Data cache counts as the last winner so the icache takes the first tie.
    localparam req_id_e LAST_GRANT_RST = REQ_DC;

endpackage

// File: rtl/axi_read_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; bit 0 is the icache, bit 1 the
// data cache. The output grant is one-hot, or zero when nobody requests.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read address/data channel pair between the icache and the
// dcache, one burst at a time, and flags bursts whose length disagrees with rlast.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_arvalid,
    input  logic [ADDR_WIDTH-1:0] ic_araddr,
    input  logic [7:0]            ic_arlen,
    input  logic [2:0]            ic_arsize,
    input  logic [1:0]            ic_arburst,
    output logic                  ic_arready,
    output logic                  ic_rvalid,
    output logic                  ic_rlast,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    input  logic                  ic_rready,

    input  logic                  dc_arvalid,
    input  logic [ADDR_WIDTH-1:0] dc_araddr,
    input  logic [7:0]            dc_arlen,
    input  logic [2:0]            dc_arsize,
    input  logic [1:0]            dc_arburst,
    output logic                  dc_arready,
    output logic                  dc_rvalid,
    output logic                  dc_rlast,
    output logic [DATA_WIDTH-1:0] dc_rdata,
    input  logic                  dc_rready,

    output logic                  m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rlast,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    output logic                  m_axi_rready,

    output logic                  instruction_cache_reading,
    output logic                  data_cache_reading,
    output logic                  burst_error,

    output logic [1:0]            dbg_state,
    output logic [7:0]            dbg_beats_left
);

    arb_state_e r_state;
    req_id_e    r_owner;
    req_id_e    r_last_grant;
    logic [7:0] r_beats_left;
    logic       r_burst_error;
    logic       r_ic_reading;
    logic       r_dc_reading;

    logic [1:0] w_grant;
    logic       w_in_addr;
    logic       w_in_data;
    logic       w_own_ic;
    logic       w_ar_hs;
    logic       w_r_hs;

    rr_pick2 u_pick (
        .i_req   ({dc_arvalid, ic_arvalid}),
        .i_last  (r_last_grant == REQ_DC),
        .o_grant (w_grant)
    );

    assign w_in_addr = (r_state == ADDR);
    assign w_in_data = (r_state == DATA);
    assign w_own_ic  = (r_owner == REQ_IC);

    // A transfer happens on a rising edge where valid and ready are both high;
    // the owner's valid/ready pass straight through, the non-owner sees neither.
    assign w_ar_hs = m_axi_arvalid & m_axi_arready;
    assign w_r_hs  = w_in_data & m_axi_rvalid & m_axi_rready;

    always_comb begin
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_arsize  = '0;
        m_axi_arburst = '0;
        if (w_in_addr) begin
            if (w_own_ic) begin
                m_axi_arvalid = ic_arvalid;
                m_axi_araddr  = ic_araddr;
                m_axi_arlen   = ic_arlen;
                m_axi_arsize  = ic_arsize;
                m_axi_arburst = ic_arburst;
            end else begin
                m_axi_arvalid = dc_arvalid;
                m_axi_araddr  = dc_araddr;
                m_axi_arlen   = dc_arlen;
                m_axi_arsize  = dc_arsize;
                m_axi_arburst = dc_arburst;
            end
        end
    end

    assign ic_arready   = w_in_addr &  w_own_ic & m_axi_arready;
    assign dc_arready   = w_in_addr & ~w_own_ic & m_axi_arready;
    assign m_axi_rready = w_in_data & (w_own_ic ? ic_rready : dc_rready);

    assign ic_rvalid = w_in_data &  w_own_ic & m_axi_rvalid;
    assign dc_rvalid = w_in_data & ~w_own_ic & m_axi_rvalid;
    assign ic_rlast  = w_in_data &  w_own_ic & m_axi_rlast;
    assign dc_rlast  = w_in_data & ~w_own_ic & m_axi_rlast;
    assign ic_rdata  = m_axi_rdata;
    assign dc_rdata  = m_axi_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_owner       <= REQ_IC;
            r_last_grant  <= LAST_GRANT_RST;
            r_beats_left  <= 8'd0;
            r_burst_error <= 1'b0;
            r_ic_reading  <= 1'b0;
            r_dc_reading  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_owner      <= w_grant[1] ? REQ_DC : REQ_IC;
                        r_ic_reading <= w_grant[0];
                        r_dc_reading <= w_grant[1];
                        r_state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_ar_hs) begin
                        r_beats_left <= m_axi_arlen;
                        r_last_grant <= r_owner;
                        r_state      <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_hs) begin
                        if (m_axi_rlast) begin
                            if (r_beats_left != 8'd0) begin
                                r_burst_error <= 1'b1;
                            end
                            r_beats_left <= 8'd0;
                            r_ic_reading <= 1'b0;
                            r_dc_reading <= 1'b0;
                            r_state      <= IDLE;
                        end else if (r_beats_left == 8'd0) begin
                            // Overrun: keep waiting for rlast, count stays at zero.
                            r_burst_error <= 1'b1;
                        end else begin
                            r_beats_left <= r_beats_left - 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign instruction_cache_reading = r_ic_reading;
    assign data_cache_reading        = r_dc_reading;
    assign burst_error               = r_burst_error;
    assign dbg_state                 = r_state;
    assign dbg_beats_left            = r_beats_left;

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the single AXI read-address/read-data channel pair between the instruction-cache fetcher and the data cache. It grants one outstanding burst at a time, with round-robin priority between the two requesters. It forwards the granted requester's AR fields to the bus, routes R beats back to the owner only, and checks burst length against `rlast`. It sits between the two cache controllers and the top-level `m_axi_*` read ports, and replaces the ad-hoc `instruction_cache_reading`/`data_cache_reading` mutual-exclusion wiring.

## Interface
- `ADDR_WIDTH`, 64, width of all AR addresses
- `DATA_WIDTH`, 64, width of R data
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `ic_arvalid`, `ic_araddr[ADDR_WIDTH]`, `ic_arlen[8]`, `ic_arsize[3]`, `ic_arburst[2]`  in  instruction-cache AR request
- `ic_arready`  out  1  AR accepted for icache
- `ic_rvalid`, `ic_rlast`  out  1; `ic_rdata`  out  DATA_WIDTH  R beats to icache
- `ic_rready`  in  1  icache accepts beat
- `dc_*`  same set as `ic_*`, for the data cache
- `m_axi_arvalid`  out  1; `m_axi_araddr`  out  ADDR_WIDTH; `m_axi_arlen`  out  8; `m_axi_arsize`  out  3; `m_axi_arburst`  out  2
- `m_axi_arready`  in  1
- `m_axi_rvalid`, `m_axi_rlast`  in  1; `m_axi_rdata`  in  DATA_WIDTH
- `m_axi_rready`  out  1
- `instruction_cache_reading`  out  1  icache owns the read channel
- `data_cache_reading`  out  1  dcache owns the read channel
- `burst_error`  out  1  sticky; burst beat count disagreed with `rlast`

## Operation
- FSM states: IDLE, ADDR, DATA. Reset state: IDLE.
- Owner register `owner` (IC/DC) and `last_grant` register. `last_grant` resets to DC, so the icache wins the first tie.
- **IDLE**
  - If exactly one `*_arvalid` is high: `owner` = that requester, go to ADDR.
  - If both are high: `owner` = the requester that is not `last_grant`, go to ADDR.
  - If neither is high: stay in IDLE.
- **ADDR**
  - `m_axi_ar*` carry the owner's AR fields combinationally, with `m_axi_arvalid` = owner `arvalid`.
  - Owner `arready` = `m_axi_arready`.
  - On handshake: load `beats_left` = owner `arlen`, set `last_grant` = `owner`, go to DATA.
- **DATA**
  - Owner `rvalid`/`rlast`/`rdata` = `m_axi_*`; `m_axi_rready` = owner `rready`.
  - On each R handshake, `beats_left` decrements.
  - On a handshake with `m_axi_rlast`=1: go to IDLE. If `beats_left`≠0 at that beat, set `burst_error`.
  - On a handshake with `beats_left`=0 and `rlast`=0: set `burst_error` and stay in DATA until `rlast`.
- Non-owner always sees `arready`=0 and `rvalid`=0. `rdata` is forwarded to both requesters unconditionally.
- Outside ADDR: `m_axi_arvalid`=0 and AR fields are 0. Outside DATA: `m_axi_rready`=0.
- `instruction_cache_reading`/`data_cache_reading` are high in ADDR and DATA for the owner; both are low in IDLE. They are never both high.
- `burst_error` is cleared only by `reset`.
- Requesters must hold `arvalid` and AR fields stable until `arready`. Dropping `arvalid` in ADDR leaves the FSM in ADDR with `m_axi_arvalid`=0 (no deadlock recovery; this is a requester protocol violation).

## Timing
- Reset values: all outputs 0, FSM in IDLE, `beats_left`=0, `last_grant`=DC.
- `reset` asserted mid-burst aborts immediately with no drain. The bus slave must be reset together with this block.
- Grant latency: `*_arvalid` high in IDLE produces `m_axi_arvalid` the next cycle.
- R path is purely combinational: 0 added latency per beat.
- After the last beat, IDLE lasts at least 1 cycle. Back-to-back bursts therefore have a 2-cycle bubble from the `rlast` handshake to the next `m_axi_arvalid`.
- `arlen`=255: `beats_left` is 8 bits; 256 beats complete without wrap error.

## Structure
- `axi_arb_pkg`: `arb_state_e` {IDLE, ADDR, DATA}, `req_id_e` {REQ_IC, REQ_DC}, reset value of `last_grant`.
- One sub-module is natural: `rr_pick2`, a combinational 2-way round-robin picker taking `req[1:0]` and `last` and producing `grant`.
- Everything else lives in this module.

## Test plan
- Icache alone: `ic_araddr`=0x1000, `arlen`=7, `arready` on the first cycle → 8 beats reach icache only; `instruction_cache_reading` is high for exactly 9 cycles; `burst_error`=0.
- Simultaneous requests after reset: IC 0x2000 and DC 0x8000 → IC is granted first, DC next with a 2-cycle bubble. A further tie goes to IC again.
- Slave holds `arready` low for 5 cycles → `m_axi_araddr` is stable throughout and `dc_arready` is high only on the handshake cycle.
- `arlen`=3 but `rlast` arrives on beat 2 → `burst_error`=1 (sticky), FSM returns to IDLE; the next clean burst leaves `burst_error`=1.
- `reset` pulsed during beat 4 of 8 → all outputs 0 the same cycle and both `*_reading` low. After release, a new IC request is granted normally.
- Owner `rready` low for 3 cycles mid-burst → `m_axi_rready` low and `beats_left` holds; all data is delivered in order.
